// File: rtl/universal_shift_register_if.sv
// Bundle between a universal_shift_register and the logic that drives it.
// master: ctrl/start/count/serial/parallel in, data/serial/busy/done out.
interface universal_shift_register_if #(
    parameter int WIDTH = 16,
    parameter int LANE  = 1,
    parameter int CNT_W = 8
);
    logic [3:0]       ctrl;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [LANE-1:0]  serial_data_input;
    logic [WIDTH-1:0] parallel_data_input;
    logic [WIDTH-1:0] data_output;
    logic [LANE-1:0]  serial_data_output;
    logic             busy;
    logic             done;

    modport master (
        output ctrl, start, count,
        output serial_data_input, parallel_data_input,
        input  data_output, serial_data_output, busy, done
    );

    modport slave (
        input  ctrl, start, count,
        input  serial_data_input, parallel_data_input,
        output data_output, serial_data_output, busy, done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Multi-mode shift register with LANE-wide steps and a repeat sequencer.
// Ports: clk, sync_nreset (sync, active-low), bus (slave side of the if).
module universal_shift_register #(
    parameter int WIDTH = 16,
    parameter int LANE  = 1,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic sync_nreset,
    universal_shift_register_if.slave bus
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_SMSB = 4'd3;
    localparam logic [3:0] OP_SLSB = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [WIDTH-1:0] r_data;
    logic [LANE-1:0]  r_sout;
    logic             r_busy;
    logic             r_done;
    logic [0:0]       r_state;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_step_data;
    logic [LANE-1:0]  w_step_out;
    logic             w_ctrl_shift;
    logic [WIDTH-1:0] w_lo_up;
    logic [WIDTH-1:0] w_hi_dn;

    // In RUN the latched op drives the shifter; ctrl only matters for abort.
    assign w_op = (r_state == S_RUN) ? r_op : bus.ctrl;

    assign w_ctrl_shift = (bus.ctrl >= OP_SMSB) && (bus.ctrl <= OP_ROR);

    // Lower bits moved up / upper bits moved down; the vacated lane is 0.
    assign w_lo_up = {r_data[WIDTH-LANE-1:0], {LANE{1'b0}}};
    assign w_hi_dn = {{LANE{1'b0}}, r_data[WIDTH-1:LANE]};

    always_comb begin
        w_step_data = r_data;
        w_step_out  = r_sout;
        case (w_op)
            OP_SMSB: begin
                w_step_data = {bus.serial_data_input, r_data[WIDTH-1:LANE]};
                w_step_out  = r_data[LANE-1:0];
            end
            OP_SLSB: begin
                w_step_data = {r_data[WIDTH-LANE-1:0], bus.serial_data_input};
                w_step_out  = r_data[WIDTH-1:WIDTH-LANE];
            end
            OP_SLL: begin
                w_step_data = w_lo_up;
                w_step_out  = r_data[WIDTH-1:WIDTH-LANE];
            end
            OP_SRL: begin
                w_step_data = w_hi_dn;
                w_step_out  = r_data[LANE-1:0];
            end
            OP_SRA: begin
                w_step_data = {{LANE{r_data[WIDTH-1]}}, r_data[WIDTH-1:LANE]};
                w_step_out  = r_data[LANE-1:0];
            end
            OP_ROL: begin
                w_step_data = w_lo_up | {{(WIDTH-LANE){1'b0}}, r_data[WIDTH-1:WIDTH-LANE]};
                w_step_out  = r_data[WIDTH-1:WIDTH-LANE];
            end
            OP_ROR: begin
                w_step_data = w_hi_dn | {r_data[LANE-1:0], {(WIDTH-LANE){1'b0}}};
                w_step_out  = r_data[LANE-1:0];
            end
            default: begin
                w_step_data = r_data;
                w_step_out  = r_sout;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            r_data  <= '0;
            r_sout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_IDLE;
            r_op    <= OP_NONE;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_ctrl_shift) begin
                        if (bus.count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_op    <= bus.ctrl;
                            r_cnt   <= bus.count;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else if (bus.ctrl == OP_CLR) begin
                        r_data <= '0;
                        r_sout <= '0;
                    end else if (bus.ctrl == OP_LOAD) begin
                        r_data <= bus.parallel_data_input;
                        r_sout <= '0;
                    end else if (w_ctrl_shift) begin
                        r_data <= w_step_data;
                        r_sout <= w_step_out;
                    end
                end
                S_RUN: begin
                    if (bus.ctrl == OP_CLR) begin
                        // Abort: no done pulse.
                        r_data  <= '0;
                        r_sout  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_data <= w_step_data;
                        r_sout <= w_step_out;
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_output        = r_data;
    assign bus.serial_data_output = r_sout;
    assign bus.busy               = r_busy;
    assign bus.done               = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (8x1 and 16x4 instances).
// Drives inputs just after posedge; samples #1 after posedge.
module tb_universal_shift_register;

    logic clk;
    logic sync_nreset;
    int   checks;
    int   errors;

    universal_shift_register_if #(.WIDTH(8),  .LANE(1), .CNT_W(8)) if8 ();
    universal_shift_register_if #(.WIDTH(16), .LANE(4), .CNT_W(8)) if16 ();

    universal_shift_register #(.WIDTH(8), .LANE(1), .CNT_W(8)) dut8 (
        .clk         (clk),
        .sync_nreset (sync_nreset),
        .bus         (if8.slave)
    );

    universal_shift_register #(.WIDTH(16), .LANE(4), .CNT_W(8)) dut16 (
        .clk         (clk),
        .sync_nreset (sync_nreset),
        .bus         (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] d,
                        input logic s, input logic b, input logic dn);
        chk({tag, ".data"}, {24'd0, if8.data_output}, {24'd0, d});
        chk({tag, ".sout"}, {31'd0, if8.serial_data_output}, {31'd0, s});
        chk({tag, ".busy"}, {31'd0, if8.busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, if8.done}, {31'd0, dn});
    endtask

    task automatic op8(input logic [3:0] c, input logic sin);
        if8.ctrl              = c;
        if8.serial_data_input = sin;
        tick();
        if8.ctrl = 4'd0;
    endtask

    task automatic load8(input logic [7:0] v);
        if8.parallel_data_input = v;
        op8(4'd2, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sync_nreset              = 1'b0;
        if8.ctrl                 = 4'd2;
        if8.start                = 1'b0;
        if8.count                = 8'd0;
        if8.serial_data_input    = 1'b0;
        if8.parallel_data_input  = 8'hA5;
        if16.ctrl                = 4'd0;
        if16.start               = 1'b0;
        if16.count               = 8'd0;
        if16.serial_data_input   = 4'h0;
        if16.parallel_data_input = 16'h0;

        // Reset wins over a parallel load
        tick();
        tick();
        chk8("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        sync_nreset = 1'b1;
        if8.ctrl    = 4'd0;

        // Single-cycle ops from 0x96
        load8(8'h96);
        chk8("load", 8'h96, 1'b0, 1'b0, 1'b0);
        op8(4'd7, 1'b0);
        chk8("sra", 8'hCB, 1'b0, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd6, 1'b0);
        chk8("srl", 8'h4B, 1'b0, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd8, 1'b0);
        chk8("rol", 8'h2D, 1'b1, 1'b0, 1'b0);
        op8(4'd0, 1'b0);
        chk8("hold", 8'h2D, 1'b1, 1'b0, 1'b0);
        op8(4'd12, 1'b0);
        chk8("reserved", 8'h2D, 1'b1, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd9, 1'b0);
        chk8("ror", 8'h4B, 1'b0, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd5, 1'b0);
        chk8("sll", 8'h2C, 1'b1, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd3, 1'b1);
        chk8("ser_msb", 8'hCB, 1'b0, 1'b0, 1'b0);
        load8(8'h96);
        op8(4'd4, 1'b1);
        chk8("ser_lsb", 8'h2D, 1'b1, 1'b0, 1'b0);
        op8(4'd1, 1'b0);
        chk8("clr", 8'h00, 1'b0, 1'b0, 1'b0);

        // start with a non-shift ctrl acts as a plain load
        if8.start               = 1'b1;
        if8.count               = 8'd4;
        if8.parallel_data_input = 8'h3C;
        op8(4'd2, 1'b0);
        if8.start = 1'b0;
        chk8("start_load", 8'h3C, 1'b0, 1'b0, 1'b0);

        // Sequenced SRA x3 from 0x81
        load8(8'h81);
        if8.start = 1'b1;
        if8.count = 8'd3;
        op8(4'd7, 1'b0);
        if8.start = 1'b0;
        if8.count = 8'd0;
        chk8("seq.e0", 8'h81, 1'b0, 1'b1, 1'b0);
        tick();
        chk8("seq.e1", 8'hC0, 1'b1, 1'b1, 1'b0);
        tick();
        chk8("seq.e2", 8'hE0, 1'b0, 1'b1, 1'b0);
        tick();
        chk8("seq.e3", 8'hF0, 1'b0, 1'b0, 1'b1);
        tick();
        chk8("seq.e4", 8'hF0, 1'b0, 1'b0, 1'b0);

        // count = 0: done pulse only
        if8.start = 1'b1;
        op8(4'd7, 1'b0);
        if8.start = 1'b0;
        chk8("cnt0.e0", 8'hF0, 1'b0, 1'b0, 1'b1);
        tick();
        chk8("cnt0.e1", 8'hF0, 1'b0, 1'b0, 1'b0);

        // Abort with CLR after two SLL steps
        load8(8'hFF);
        if8.start = 1'b1;
        if8.count = 8'd6;
        op8(4'd5, 1'b0);
        if8.start = 1'b0;
        chk8("abort.e0", 8'hFF, 1'b0, 1'b1, 1'b0);
        tick();
        chk8("abort.e1", 8'hFE, 1'b1, 1'b1, 1'b0);
        tick();
        chk8("abort.e2", 8'hFC, 1'b1, 1'b1, 1'b0);
        op8(4'd1, 1'b0);
        chk8("abort.clr", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk8("abort.nodone", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a sequence
        load8(8'h55);
        if8.start = 1'b1;
        if8.count = 8'd5;
        op8(4'd8, 1'b0);
        if8.start = 1'b0;
        tick();
        chk8("rst_mid.run", 8'hAA, 1'b0, 1'b1, 1'b0);
        sync_nreset = 1'b0;
        tick();
        sync_nreset = 1'b1;
        chk8("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk8("rst_mid.idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // 16-bit, 4-bit lane serial load at LSB
        if16.parallel_data_input = 16'h1234;
        if16.ctrl                = 4'd2;
        tick();
        if16.ctrl              = 4'd4;
        if16.serial_data_input = 4'hF;
        tick();
        if16.ctrl = 4'd0;
        chk("lane4.data", {16'd0, if16.data_output}, 32'h234F);
        chk("lane4.sout", {28'd0, if16.serial_data_output}, 32'h1);
        chk("lane4.busy", {31'd0, if16.busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
